// File: rtl/ascon_pkg.sv
// Shared types and register map for the ASCON register-interface initiator.
// The reg_req_t/reg_rsp_t bus structs live here so initiator and bench agree.
package ascon_pkg;

  typedef logic [4:0][63:0] state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

  localparam int          NUM_WORDS       = 10;
  localparam logic [31:0] STATE_OFFS      = 32'h0000_0000;
  localparam logic [31:0] CTRL_OFFS       = 32'h0000_0028;
  localparam logic [31:0] STATUS_OFFS     = 32'h0000_002C;
  localparam int          CTRL_START      = 0;
  localparam int          STATUS_FINISHED = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_STATE,
    S_WR_START,
    S_WAIT,
    S_RD_STATUS,
    S_RD_STATE,
    S_RESP
  } fsm_e;

  // Word k of the register view is the low half of lane k/2 for even k.
  function automatic logic [31:0] state_word(input state_t s, input logic [3:0] k);
    logic [63:0] lane;
    lane = s[k[3:1]];
    return k[0] ? lane[63:32] : lane[31:0];
  endfunction

endpackage

// File: rtl/ascon_reg_initiator.sv
// Drives the ASCON accelerator register slave for one 320-bit permutation job:
// write state, pulse START, wait on interrupt or STATUS polling, read state back.
module ascon_reg_initiator
  import ascon_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int unsigned POLL_INTERVAL = 16,
  parameter int unsigned TIMEOUT       = 4096
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     job_valid_i,
  output logic     job_ready_o,
  input  state_t   job_state_i,
  output logic     res_valid_o,
  input  logic     res_ready_i,
  output state_t   res_state_o,
  output logic     res_err_o,
  output reg_req_t reg_req_o,
  input  reg_rsp_t reg_rsp_i,
  input  logic     intr_i,
  output logic     busy_o
);

  localparam logic [3:0]  LAST_WORD = 4'(NUM_WORDS - 1);
  localparam logic [31:0] POLL_LAST = 32'(POLL_INTERVAL - 1);
  localparam logic [31:0] WAIT_LAST = 32'(TIMEOUT - 1);

  fsm_e        state, state_nx;
  logic [3:0]  word, word_nx;
  logic [31:0] poll_cnt, poll_nx;
  logic [31:0] wait_cnt, wait_nx;
  logic        err_q;
  state_t      res_q;
  state_t      job_q;

  logic        latch, cap, err_set, err_clr;
  logic        xfer_done, xfer_err;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  assign xfer_done = reg_req_o.valid && reg_rsp_i.ready;
  assign xfer_err  = xfer_done && reg_rsp_i.error;

  // Request fields are decoded from registered state only, so an asynchronous
  // reset withdraws valid in the same cycle.
  always_comb begin
    reg_req_o = '0;
    unique case (state)
      S_WR_STATE: begin
        reg_req_o.valid = 1'b1;
        reg_req_o.write = 1'b1;
        reg_req_o.addr  = BASE_ADDR + STATE_OFFS + 32'({word, 2'b00});
        reg_req_o.wdata = state_word(job_q, word);
        reg_req_o.wstrb = 4'hF;
      end
      S_WR_START: begin
        reg_req_o.valid = 1'b1;
        reg_req_o.write = 1'b1;
        reg_req_o.addr  = BASE_ADDR + CTRL_OFFS;
        reg_req_o.wdata = 32'd1 << CTRL_START;
        reg_req_o.wstrb = 4'hF;
      end
      S_RD_STATUS: begin
        reg_req_o.valid = 1'b1;
        reg_req_o.addr  = BASE_ADDR + STATUS_OFFS;
      end
      S_RD_STATE: begin
        reg_req_o.valid = 1'b1;
        reg_req_o.addr  = BASE_ADDR + STATE_OFFS + 32'({word, 2'b00});
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    word_nx  = word;
    poll_nx  = poll_cnt;
    wait_nx  = wait_cnt;
    latch    = 1'b0;
    cap      = 1'b0;
    err_set  = 1'b0;
    err_clr  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (job_valid_i) begin
          latch    = 1'b1;
          err_clr  = 1'b1;
          word_nx  = '0;
          state_nx = S_WR_STATE;
        end
      end
      S_WR_STATE: begin
        if (xfer_err) begin
          err_set  = 1'b1;
          state_nx = S_RESP;
        end else if (xfer_done) begin
          if (word == LAST_WORD) begin
            word_nx  = '0;
            state_nx = S_WR_START;
          end else begin
            word_nx = word + 4'd1;
          end
        end
      end
      S_WR_START: begin
        if (xfer_err) begin
          err_set  = 1'b1;
          state_nx = S_RESP;
        end else if (xfer_done) begin
          poll_nx  = '0;
          wait_nx  = '0;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        wait_nx = sat_inc(wait_cnt);
        if (intr_i) begin
          poll_nx  = '0;
          state_nx = S_RD_STATUS;
        end else if (TIMEOUT != 0 && wait_cnt >= WAIT_LAST) begin
          err_set  = 1'b1;
          state_nx = S_RESP;
        end else if (poll_cnt >= POLL_LAST) begin
          poll_nx  = '0;
          state_nx = S_RD_STATUS;
        end else begin
          poll_nx = sat_inc(poll_cnt);
        end
      end
      S_RD_STATUS: begin
        if (xfer_err) begin
          err_set  = 1'b1;
          state_nx = S_RESP;
        end else if (xfer_done) begin
          if (reg_rsp_i.rdata[STATUS_FINISHED]) begin
            word_nx  = '0;
            state_nx = S_RD_STATE;
          end else begin
            state_nx = S_WAIT;
          end
        end
      end
      S_RD_STATE: begin
        if (xfer_err) begin
          err_set  = 1'b1;
          state_nx = S_RESP;
        end else if (xfer_done) begin
          cap = 1'b1;
          if (word == LAST_WORD) begin
            state_nx = S_RESP;
          end else begin
            word_nx = word + 4'd1;
          end
        end
      end
      S_RESP: begin
        if (res_ready_i) begin
          err_clr  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      word     <= '0;
      poll_cnt <= '0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
      res_q    <= '0;
    end else begin
      state    <= state_nx;
      word     <= word_nx;
      poll_cnt <= poll_nx;
      wait_cnt <= wait_nx;
      if (err_set) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
      // Result is cleared per job so an aborted read leaves zeros past the last good word.
      if (latch) begin
        res_q <= '0;
      end else if (cap) begin
        if (word[0]) begin
          res_q[word[3:1]][63:32] <= reg_rsp_i.rdata;
        end else begin
          res_q[word[3:1]][31:0] <= reg_rsp_i.rdata;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (latch) begin
      job_q <= job_state_i;
    end
  end

  assign job_ready_o = (state == S_IDLE);
  assign busy_o      = (state != S_IDLE);
  assign res_valid_o = (state == S_RESP);
  assign res_err_o   = err_q;
  assign res_state_o = res_q;

endmodule

// File: tb/tb_ascon_reg_initiator.sv
// Directed bench: a register-slave model with configurable wait states, error
// injection and FINISHED timing returns the bitwise inverse of the written state.
module tb_ascon_reg_initiator;
  import ascon_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic     clk = 1'b0;
  logic     rst;
  logic     job_valid;
  logic     job_ready;
  state_t   job_state;
  logic     res_valid;
  logic     res_ready;
  state_t   res_state;
  logic     res_err;
  reg_req_t req;
  reg_rsp_t rsp;
  logic     intr;
  logic     busy;

  ascon_reg_initiator #(
    .BASE_ADDR(BASE),
    .POLL_INTERVAL(16),
    .TIMEOUT(100)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .job_valid_i(job_valid),
    .job_ready_o(job_ready),
    .job_state_i(job_state),
    .res_valid_o(res_valid),
    .res_ready_i(res_ready),
    .res_state_o(res_state),
    .res_err_o(res_err),
    .reg_req_o(req),
    .reg_rsp_i(rsp),
    .intr_i(intr),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // slave model state
  int          waits = 0;
  int          mode = 0;
  int          err_word = -1;
  int          wcnt = 0;
  int          wait_cyc = 0;
  int          n_wr = 0, n_rd = 0, n_stat = 0;
  int          seq_bad = 0, stab_bad = 0;
  int          stat_wc[8];
  logic [31:0] mem[10];
  reg_req_t    held;
  state_t      cur_job;

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic grant();
    logic [63:0] lane;
    logic [31:0] half;
    logic        fin;
    fin = (mode == 0) ? 1'b1 : (mode == 1) ? (wait_cyc >= 50) : 1'b0;
    if (req.write) begin
      if (n_wr < 10) begin
        lane = cur_job[n_wr / 2];
        half = (n_wr % 2 == 1) ? lane[63:32] : lane[31:0];
        if (req.addr != BASE + 32'(4 * n_wr) || req.wdata != half || req.wstrb != 4'hF) seq_bad++;
        mem[n_wr] = req.wdata;
      end else if (n_wr == 10) begin
        if (req.addr != BASE + 32'h28 || req.wdata != 32'h1 || req.wstrb != 4'hF) seq_bad++;
      end else begin
        seq_bad++;
      end
      if (n_wr == err_word) rsp.error = 1'b1;
      n_wr++;
    end else begin
      if (req.wstrb != 4'h0) seq_bad++;
      if (req.addr == BASE + 32'h2C) begin
        if (n_wr != 11 || n_rd != 0) seq_bad++;
        if (n_stat < 8) stat_wc[n_stat] = wait_cyc;
        n_stat++;
        rsp.rdata = {31'b0, fin};
      end else begin
        if (n_rd >= 10 || req.addr != BASE + 32'(4 * n_rd)) seq_bad++;
        else rsp.rdata = ~mem[n_rd];
        n_rd++;
      end
    end
    rsp.ready = 1'b1;
  endtask

  // Slave decides its response at the falling edge; the DUT samples it at the next rising edge.
  initial begin
    rsp = '0;
    forever begin
      @(negedge clk);
      rsp = '0;
      if (rst || !req.valid) begin
        wcnt = 0;
        if (!rst && busy && n_wr == 11 && n_rd == 0) wait_cyc++;
      end else begin
        if (wcnt > 0 && req !== held) stab_bad++;
        if (wcnt == 0) held = req;
        if (wcnt < waits) wcnt++;
        else begin
          wcnt = 0;
          grant();
        end
      end
    end
  end

  task automatic make_job(input int v, output state_t j);
    for (int l = 0; l < 5; l++) j[l] = (64'h0123456789ABCDEF * 64'(l + 1)) ^ (64'(v) << 40);
  endtask

  task automatic run_job(input state_t j, input logic exp_err, input int exp_lat,
                         input int exp_wr, input int exp_rd, input int exp_stat);
    int     lat;
    state_t exp_state;
    cur_job = j;
    n_wr = 0; n_rd = 0; n_stat = 0; seq_bad = 0; wait_cyc = 0;
    check("idle_ready", job_ready, 1'b1);
    job_state = j;
    job_valid = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    // Keep offering a different job; it must not be taken while busy.
    job_state = ~j ^ {5{64'hA5A5_5A5A_0F0F_F0F0}};
    while (!res_valid && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    job_valid = 1'b0;
    check("latency", lat, exp_lat);
    repeat (2) @(posedge clk);
    #1;
    check("resp_hold", res_valid, 1'b1);
    exp_state = exp_err ? '0 : ~j;
    check("res_err", res_err, exp_err);
    check("res_state", res_state, exp_state);
    check("n_writes", n_wr, exp_wr);
    check("n_reads", n_rd, exp_rd);
    check("n_status", n_stat, exp_stat);
    check("bus_seq", seq_bad, 0);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("post_idle", {job_ready, res_valid, res_err}, 3'b100);
  endtask

  typedef struct {
    int   waits;
    int   mode;
    int   err_word;
    logic exp_err;
    int   exp_lat;
    int   exp_wr;
    int   exp_rd;
    int   exp_stat;
  } vec_t;

  vec_t   vecs[6];
  state_t j;
  int     found;

  initial begin
    rst = 1'b1; job_valid = 1'b0; job_state = '0; res_ready = 1'b0; intr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_job_ready", job_ready, 1'b1);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_err", res_err, 1'b0);
    check("rst_res_state", res_state, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_req", req, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    //        waits mode err  err  lat  wr  rd stat
    vecs[0] = '{0, 0, -1, 1'b0, 24,  11, 10, 1};
    vecs[1] = '{3, 0, -1, 1'b0, 90,  11, 10, 1};
    vecs[2] = '{0, 1, -1, 1'b0, 90,  11, 10, 4};
    vecs[3] = '{0, 0,  4, 1'b1, 6,   5,  0,  0};
    vecs[4] = '{0, 2, -1, 1'b1, 118, 11, 0,  6};
    vecs[5] = '{0, 0, -1, 1'b0, 24,  11, 10, 1};

    for (int v = 0; v < 6; v++) begin
      waits = vecs[v].waits;
      mode = vecs[v].mode;
      err_word = vecs[v].err_word;
      intr = (mode == 0);
      make_job(v, j);
      run_job(j, vecs[v].exp_err, vecs[v].exp_lat, vecs[v].exp_wr, vecs[v].exp_rd, vecs[v].exp_stat);
      if (mode != 0)
        for (int i = 0; i < n_stat && i < 8; i++) check("poll_wait_cycle", stat_wc[i], 16 * (i + 1));
    end
    check("req_stable", stab_bad, 0);

    // Reset while reading state word 3.
    waits = 0; mode = 0; err_word = -1; intr = 1'b1;
    make_job(7, j);
    cur_job = j;
    n_wr = 0; n_rd = 0; n_stat = 0; seq_bad = 0; wait_cyc = 0;
    job_state = j;
    job_valid = 1'b1;
    @(posedge clk); #1;
    job_valid = 1'b0;
    found = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      @(posedge clk); #1;
      if (req.valid && !req.write && req.addr == BASE + 32'hC) found = 1;
    end
    check("reach_rd_word3", found, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_req", req, '0);
    check("mid_rst_outputs", {job_ready, res_valid, res_err, busy}, 4'b1000);
    check("mid_rst_res_state", res_state, '0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    make_job(8, j);
    run_job(j, 1'b0, 24, 11, 10, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "bench watchdog expired");
  end

endmodule
